lru_replace_ctrl: RTL and testbench

- Initiator side of the `lru` update interface.
- Accepts cache lookup results, selects a victim way on a miss, holds it until the fill completes, then issues the MRU update (`mru_in`/`index_in`/`load_in`) to `lru`.
- Sits between the cache control FSM and the `lru` array; keeps saturating hit and miss counters for performance analysis.

---
 rtl/lru_replace_ctrl_if.sv | 42 ++++
 rtl/lru_replace_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_lru_replace_ctrl.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lru_replace_ctrl_if.sv
// Cache-side port bundle of the LRU replacement controller: lookup results,
// the victim handshake, and fill completion.
interface lru_replace_ctrl_if #(
    parameter int SET           = 8,
    parameter int ASSOCIATIVITY = 4
) ();
    localparam int LRU_WIDTH = $clog2(ASSOCIATIVITY);
    localparam int IDX_WIDTH = $clog2(SET);

    logic                     req_valid;
    logic                     req_ready;
    logic [IDX_WIDTH-1:0]     req_index;
    logic [ASSOCIATIVITY-1:0] hit_vec;
    logic [ASSOCIATIVITY-1:0] valid_vec;
    logic                     victim_valid;
    logic [LRU_WIDTH-1:0]     victim_way;
    logic                     fill_done;

    // Cache control FSM side.
    modport master (
        output req_valid,
        output req_index,
        output hit_vec,
        output valid_vec,
        output fill_done,
        input  req_ready,
        input  victim_valid,
        input  victim_way
    );

    // Replacement controller side.
    modport slave (
        input  req_valid,
        input  req_index,
        input  hit_vec,
        input  valid_vec,
        input  fill_done,
        output req_ready,
        output victim_valid,
        output victim_way
    );
endinterface

// File: rtl/lru_replace_ctrl.sv
// LRU replacement controller: turns lookup results into a victim choice,
// waits for the fill, then pulses the MRU update into the lru array.
module lru_replace_ctrl #(
    parameter int SET           = 8,
    parameter int ASSOCIATIVITY = 4,
    parameter int LRU_WIDTH     = $clog2(ASSOCIATIVITY),
    parameter int IDX_WIDTH     = $clog2(SET),
    parameter int CNT_WIDTH     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    lru_replace_ctrl_if.slave    bus,
    output logic [IDX_WIDTH-1:0] lru_index_out,
    output logic [LRU_WIDTH-1:0] mru_out,
    output logic                 load_lru_out,
    input  logic [LRU_WIDTH-1:0] lru_in,
    output logic                 multi_hit_err,
    output logic [CNT_WIDTH-1:0] hit_cnt,
    output logic [CNT_WIDTH-1:0] miss_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_VICTIM = 2'd2,
        ST_UPDATE = 2'd3
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic [IDX_WIDTH-1:0]     index_reg;
    logic [LRU_WIDTH-1:0]     victim_reg;
    logic [LRU_WIDTH-1:0]     mru_reg;
    logic                     multi_reg;
    logic [CNT_WIDTH-1:0]     hit_cnt_reg;
    logic [CNT_WIDTH-1:0]     miss_cnt_reg;

    logic                     accept;
    logic                     is_hit;
    logic                     set_full;
    logic                     hit_multi;
    logic [ASSOCIATIVITY-1:0] free_vec;
    logic [ASSOCIATIVITY-1:0] hit_first;
    logic [ASSOCIATIVITY-1:0] free_first;
    logic [LRU_WIDTH-1:0]     hit_way;
    logic [LRU_WIDTH-1:0]     free_way;

    assign accept    = bus.req_valid && (state_reg == ST_IDLE);
    assign is_hit    = |bus.hit_vec;
    assign set_full  = &bus.valid_vec;
    assign free_vec  = ~bus.valid_vec;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign hit_multi = (bus.hit_vec & (bus.hit_vec - ASSOCIATIVITY'(1))) != '0;

    // Isolate the lowest set bit of the hit and free vectors.
    genvar gi;
    generate
        for (gi = 0; gi < ASSOCIATIVITY; gi++) begin : g_first
            if (gi == 0) begin : g_lsb
                assign hit_first[gi]  = bus.hit_vec[gi];
                assign free_first[gi] = free_vec[gi];
            end else begin : g_upper
                assign hit_first[gi]  = bus.hit_vec[gi] & ~(|bus.hit_vec[gi-1:0]);
                assign free_first[gi] = free_vec[gi] & ~(|free_vec[gi-1:0]);
            end
        end
    endgenerate

    // One-hot to binary; at most one bit of each *_first vector is set.
    always_comb begin
        hit_way  = '0;
        free_way = '0;
        for (int i = 0; i < ASSOCIATIVITY; i++) begin
            if (hit_first[i]) begin
                hit_way = hit_way | LRU_WIDTH'(i);
            end
            if (free_first[i]) begin
                free_way = free_way | LRU_WIDTH'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    if (is_hit) begin
                        state_next = ST_UPDATE;
                    end else if (set_full) begin
                        state_next = ST_LOOKUP;
                    end else begin
                        state_next = ST_VICTIM;
                    end
                end
            end
            ST_LOOKUP: state_next = ST_VICTIM;
            ST_VICTIM: begin
                if (bus.fill_done) begin
                    state_next = ST_UPDATE;
                end
            end
            ST_UPDATE: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Request capture and way selection. lru_in is the lru array's read of
    // index_reg, which has settled by the LOOKUP cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            index_reg  <= '0;
            victim_reg <= '0;
            mru_reg    <= '0;
        end else begin
            if (accept) begin
                index_reg <= bus.req_index;
                if (is_hit) begin
                    mru_reg <= hit_way;
                end else if (!set_full) begin
                    victim_reg <= free_way;
                end
            end
            if (state_reg == ST_LOOKUP) begin
                victim_reg <= lru_in;
            end
            if ((state_reg == ST_VICTIM) && bus.fill_done) begin
                mru_reg <= victim_reg;
            end
        end
    end

    // Performance counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_reg  <= '0;
            miss_cnt_reg <= '0;
            multi_reg    <= 1'b0;
        end else if (accept) begin
            if (is_hit) begin
                if (hit_cnt_reg != '1) begin
                    hit_cnt_reg <= hit_cnt_reg + CNT_WIDTH'(1);
                end
                if (hit_multi) begin
                    multi_reg <= 1'b1;
                end
            end else if (miss_cnt_reg != '1) begin
                miss_cnt_reg <= miss_cnt_reg + CNT_WIDTH'(1);
            end
        end
    end

    // Strobes decode straight from the state register so reset clears them
    // at once and can never leave a load pulse behind.
    assign bus.req_ready    = (state_reg == ST_IDLE);
    assign bus.victim_valid = (state_reg == ST_VICTIM);
    assign bus.victim_way   = victim_reg;
    assign load_lru_out     = (state_reg == ST_UPDATE);
    assign mru_out          = mru_reg;
    assign lru_index_out    = index_reg;
    assign multi_hit_err    = multi_reg;
    assign hit_cnt          = hit_cnt_reg;
    assign miss_cnt         = miss_cnt_reg;

    a_load_single: assert property (@(posedge clk) disable iff (rst)
        load_lru_out |=> !load_lru_out);

    a_lookup_one_cycle: assert property (@(posedge clk) disable iff (rst)
        (state_reg == ST_LOOKUP) |=> (state_reg == ST_VICTIM));

    a_victim_stable: assert property (@(posedge clk) disable iff (rst)
        (bus.victim_valid && !bus.fill_done) |=> (bus.victim_valid && $stable(bus.victim_way)));

endmodule

// File: tb/tb_lru_replace_ctrl.sv
// Randomized bench for lru_replace_ctrl with a request-level reference model
// and a behavioural lru array answering lookups.
module tb_lru_replace_ctrl;
    localparam int SET   = 8;
    localparam int ASSOC = 4;
    localparam int LW    = 2;
    localparam int IW    = 3;
    localparam int CW    = 2;
    localparam int SAT   = (1 << CW) - 1;
    localparam int FULL  = (1 << ASSOC) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [IW-1:0] lru_index_out;
    logic [LW-1:0] mru_out;
    logic          load_lru_out;
    logic [LW-1:0] lru_in;
    logic          multi_hit_err;
    logic [CW-1:0] hit_cnt;
    logic [CW-1:0] miss_cnt;

    int checks = 0;
    int errors = 0;
    int txn    = 0;
    int lru_mem [SET];

    int exp_hits   = 0;
    int exp_misses = 0;
    int exp_multi  = 0;

    lru_replace_ctrl_if #(.SET(SET), .ASSOCIATIVITY(ASSOC)) bus ();

    lru_replace_ctrl #(
        .SET(SET), .ASSOCIATIVITY(ASSOC), .LRU_WIDTH(LW), .IDX_WIDTH(IW), .CNT_WIDTH(CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .lru_index_out (lru_index_out),
        .mru_out       (mru_out),
        .load_lru_out  (load_lru_out),
        .lru_in        (lru_in),
        .multi_hit_err (multi_hit_err),
        .hit_cnt       (hit_cnt),
        .miss_cnt      (miss_cnt)
    );

    always #5 clk = ~clk;

    // The lru array's answer for whatever set the controller is addressing.
    assign lru_in = LW'(lru_mem[lru_index_out]);

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int lowest_one(input logic [ASSOC-1:0] v);
        for (int i = 0; i < ASSOC; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic int ones(input logic [ASSOC-1:0] v);
        int n = 0;
        for (int i = 0; i < ASSOC; i++) n += int'(v[i]);
        return n;
    endfunction

    task automatic check_counters(input string tag);
        check_val({tag, "_hit_cnt"}, 32'(hit_cnt), 32'(exp_hits));
        check_val({tag, "_miss_cnt"}, 32'(miss_cnt), 32'(exp_misses));
        check_val({tag, "_multi"}, 32'(multi_hit_err), 32'(exp_multi));
    endtask

    task automatic model_reset();
        exp_hits   = 0;
        exp_misses = 0;
        exp_multi  = 0;
    endtask

    // One complete request, entered and left at a negedge with the DUT idle.
    task automatic run_req(input int idx, input logic [ASSOC-1:0] hv, input logic [ASSOC-1:0] vv,
                           input int fill_wait, input bit hold_in_update, input bit stray_fill);
        bit is_hit;
        bit full;
        int way;
        is_hit = (hv != '0);
        full   = (vv == FULL[ASSOC-1:0]);
        if (is_hit)    way = lowest_one(hv);
        else if (full) way = lru_mem[idx];
        else           way = lowest_one(~vv);
        txn++;
        $display("txn %0d: idx=%0d hit_vec=%b valid_vec=%b -> %s way %0d",
                 txn, idx, hv, vv, is_hit ? "hit" : (full ? "miss-full" : "miss-free"), way);

        check_val("idle_ready", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_index = IW'(idx);
        bus.hit_vec   = hv;
        bus.valid_vec = vv;
        bus.fill_done = stray_fill;
        @(posedge clk);
        if (is_hit) begin
            exp_hits = (exp_hits < SAT) ? exp_hits + 1 : SAT;
            if (ones(hv) > 1) exp_multi = 1;
        end else begin
            exp_misses = (exp_misses < SAT) ? exp_misses + 1 : SAT;
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_index = IW'($urandom_range(0, SET - 1));
        bus.hit_vec   = ASSOC'($urandom);
        bus.valid_vec = ASSOC'($urandom);
        bus.fill_done = 1'b0;

        if (!is_hit) begin
            if (full) begin
                check_val("lookup_victim_valid", 32'(bus.victim_valid), 32'd0);
                check_val("lookup_load", 32'(load_lru_out), 32'd0);
                check_val("lookup_ready", 32'(bus.req_ready), 32'd0);
                bus.fill_done = stray_fill;
                @(negedge clk);
                bus.fill_done = 1'b0;
            end
            check_val("victim_valid", 32'(bus.victim_valid), 32'd1);
            check_val("victim_way", 32'(bus.victim_way), 32'(way));
            check_val("victim_ready", 32'(bus.req_ready), 32'd0);
            check_val("victim_load", 32'(load_lru_out), 32'd0);
            for (int w = 0; w < fill_wait; w++) begin
                @(negedge clk);
                check_val("victim_hold", 32'(bus.victim_valid), 32'd1);
                check_val("victim_way_hold", 32'(bus.victim_way), 32'(way));
            end
            bus.fill_done = 1'b1;
            @(negedge clk);
            bus.fill_done = 1'b0;
        end

        check_val("update_load", 32'(load_lru_out), 32'd1);
        check_val("update_mru", 32'(mru_out), 32'(way));
        check_val("update_index", 32'(lru_index_out), 32'(idx));
        check_val("update_victim_valid", 32'(bus.victim_valid), 32'd0);
        check_val("update_ready", 32'(bus.req_ready), 32'd0);
        check_counters("update");
        if (hold_in_update) begin
            bus.req_valid = 1'b1;
            bus.hit_vec   = ASSOC'($urandom);
        end
        lru_mem[idx] = $urandom_range(0, ASSOC - 1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check_val("after_load", 32'(load_lru_out), 32'd0);
        check_val("after_ready", 32'(bus.req_ready), 32'd1);
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
        check_val({tag, "_victim_valid"}, 32'(bus.victim_valid), 32'd0);
        check_val({tag, "_load"}, 32'(load_lru_out), 32'd0);
        check_val({tag, "_hit_cnt"}, 32'(hit_cnt), 32'd0);
        check_val({tag, "_miss_cnt"}, 32'(miss_cnt), 32'd0);
        check_val({tag, "_multi"}, 32'(multi_hit_err), 32'd0);
    endtask

    initial begin
        logic [ASSOC-1:0] hv;
        logic [ASSOC-1:0] vv;
        int kind;

        bus.req_valid = 1'b0;
        bus.req_index = '0;
        bus.hit_vec   = '0;
        bus.valid_vec = '0;
        bus.fill_done = 1'b0;
        for (int s = 0; s < SET; s++) lru_mem[s] = $urandom_range(0, ASSOC - 1);

        repeat (2) @(negedge clk);
        check_reset_state("reset");
        check_val("reset_mru", 32'(mru_out), 32'd0);
        check_val("reset_victim_way", 32'(bus.victim_way), 32'd0);
        check_val("reset_index", 32'(lru_index_out), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases.
        run_req(3, 4'b0100, 4'b1111, 0, 0, 0);
        run_req(0, 4'b0000, 4'b1011, 3, 0, 0);
        lru_mem[5] = 1;
        run_req(5, 4'b0000, 4'b1111, 0, 0, 1);
        run_req(2, 4'b1010, 4'b1111, 0, 0, 0);
        run_req(6, 4'b1000, 4'b1111, 1, 1, 1);
        check_val("multi_sticky", 32'(multi_hit_err), 32'd1);

        // Reset while a victim is outstanding.
        bus.req_valid = 1'b1;
        bus.req_index = 3'd4;
        bus.hit_vec   = 4'b0000;
        bus.valid_vec = 4'b0111;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check_val("pre_reset_victim", 32'(bus.victim_valid), 32'd1);
        rst = 1'b1;
        #1;
        model_reset();
        check_reset_state("midreset");
        @(negedge clk);
        rst = 1'b0;
        bus.fill_done = 1'b1;
        @(negedge clk);
        bus.fill_done = 1'b0;
        check_val("stray_fill_load", 32'(load_lru_out), 32'd0);
        check_val("stray_fill_victim", 32'(bus.victim_valid), 32'd0);
        @(negedge clk);
        check_val("stray_fill_load2", 32'(load_lru_out), 32'd0);

        // Saturation: five back-to-back hits with req_valid held through UPDATE.
        for (int k = 0; k < 5; k++) run_req(k, 4'b0001 << (k % ASSOC), 4'b1111, 0, 1, 0);
        check_val("sat_hit_cnt", 32'(hit_cnt), 32'(SAT));

        // Randomized traffic.
        for (int n = 0; n < 250; n++) begin
            kind = $urandom_range(0, 9);
            if (kind < 4) begin
                hv = ASSOC'($urandom);
                if (hv == '0) hv = ASSOC'(1) << $urandom_range(0, ASSOC - 1);
                if ($urandom_range(0, 2) != 0) hv = ASSOC'(1) << lowest_one(hv);
                vv = FULL[ASSOC-1:0];
            end else if (kind < 7) begin
                hv = '0;
                vv = ASSOC'($urandom);
                if (vv == FULL[ASSOC-1:0]) vv[$urandom_range(0, ASSOC - 1)] = 1'b0;
            end else begin
                hv = '0;
                vv = FULL[ASSOC-1:0];
            end
            run_req($urandom_range(0, SET - 1), hv, vv, $urandom_range(0, 3),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if (n == 120) begin
                rst = 1'b1;
                #1;
                model_reset();
                check_reset_state("rand_reset");
                @(negedge clk);
                rst = 1'b0;
                @(negedge clk);
            end
        end
        check_counters("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end
endmodule
